// File: rtl/fetch_issue_unit.sv
// Fetch/issue front end: owns the PC, fetches one word at a time and holds it for decode under valid/ready.
// Optional FETCH_ISSUE_UNIT_PERF_EN adds a saturating issue_count of accepted instructions.
module fetch_issue_unit #(
    parameter int unsigned          WORD_W  = 32,
    parameter logic [WORD_W-1:0]    PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              halt,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] pc_plus4,
`ifdef FETCH_ISSUE_UNIT_PERF_EN
    output logic [31:0]       issue_count,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetchState_e;

    fetchState_e       state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] pcPlus4_q;
    logic              instrValid_q;
    logic              halted_q;

    logic [WORD_W-1:0] pcInc_d;
    logic [WORD_W-1:0] redirectPc_d;
    logic              accept_d;

    // Addition wraps naturally at the top of the address space.
    assign pcInc_d      = pc_q + WORD_W'(4);
    assign redirectPc_d = {redirect_pc[WORD_W-1:2], 2'b00};
    assign accept_d     = instrValid_q & instr_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            instr_q      <= '0;
            pcPlus4_q    <= '0;
            instrValid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    // A redirect beats a returning word: the word is dropped and the PC is not bumped.
                    if (redirect) begin
                        pc_q         <= redirectPc_d;
                        instrValid_q <= 1'b0;
                    end else if (ihit) begin
                        instr_q      <= imemload;
                        pcPlus4_q    <= pcInc_d;
                        pc_q         <= pcInc_d;
                        instrValid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    // instr itself is kept on a squash; only the valid flag drops.
                    if (redirect) begin
                        pc_q         <= redirectPc_d;
                        instrValid_q <= 1'b0;
                        state_q      <= FETCH;
                    end else if (accept_d) begin
                        instrValid_q <= 1'b0;
                        if (halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else begin
                            state_q  <= FETCH;
                        end
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_q      <= FETCH;
                    instrValid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ISSUE_UNIT_PERF_EN
    logic [31:0] issueCount_q;

    // Counts only real acceptances; a same-cycle redirect wins and is not counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            issueCount_q <= '0;
        end else if (state_q == HOLD && !redirect && accept_d && issueCount_q != 32'hFFFF_FFFF) begin
            issueCount_q <= issueCount_q + 32'd1;
        end
    end

    assign issue_count = issueCount_q;
`endif

    assign imemREN     = (state_q == FETCH) & ~RST;
    assign imemaddr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instrValid_q;
    assign pc_plus4    = pcPlus4_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Instruction-side producer for the control unit: owns the PC, reads instruction memory, and presents one instruction word at a time on the word that drives the control unit's instruction input.
- Uses a valid/ready handshake toward decode.
- Stops permanently when decode reports halt on an accepted instruction.
- Accepts branch/jump redirects from execute.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- WORD_W, 32, width of PC, addresses and instruction words.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- imemREN  output  1  instruction memory read enable.
- imemaddr  output  WORD_W  instruction memory address, equals current PC.
- ihit  input  1  memory returns imemload this cycle.
- imemload  input  WORD_W  instruction data from memory.
- instr  output  WORD_W  held instruction word; drives the control unit instr input.
- instr_valid  output  1  instr holds a live instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- halt  input  1  control unit halt decode of the current instr.
- redirect  input  1  load redirect_pc and squash.
- redirect_pc  input  WORD_W  redirect target.
- pc_plus4  output  WORD_W  address of held instruction + 4, registered with instr.
- halted  output  1  sticky fetch-stopped flag.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST); it overrides all other inputs in the same edge.
- Reset values:
  - pc = PC_INIT; state = FETCH.
  - instr = 0; instr_valid = 0; pc_plus4 = 0.
  - halted = 0; imemREN = 0 during the reset cycle.
- States: FETCH, HOLD, HALTED.
- Outputs by state:
  - imemREN = 1 only in FETCH and when RST = 0.
  - imemaddr = pc at all times.
- FETCH:
  - On ihit: instr <= imemload; pc_plus4 <= pc + 4; pc <= pc + 4 (modulo 2^WORD_W, wraps 32'hFFFF_FFFC -> 0); instr_valid <= 1; go to HOLD.
  - Without ihit: remain in FETCH with imemREN held at 1; no timeout.
- HOLD:
  - imemREN = 0; instr and instr_valid stable until accepted.
  - Acceptance = instr_valid & instr_ready.
  - On acceptance with halt = 1: instr_valid <= 0; halted <= 1; go to HALTED.
  - On acceptance with halt = 0: instr_valid <= 0; go to FETCH.
  - Minimum issue rate: one instruction per 2 cycles plus memory latency.
- halt is sampled only on acceptance; halt while instr_valid = 0 or instr_ready = 0 is ignored.
- Redirect (FETCH or HOLD):
  - pc <= {redirect_pc[WORD_W-1:2], 2'b00}; instr_valid <= 0; go to FETCH.
  - Redirect has priority over ihit (returned word discarded, pc not incremented) and over acceptance (halt ignored that cycle).
  - instr is not cleared on redirect; only instr_valid drops.
- HALTED:
  - Terminal until RST. imemREN = 0; instr_valid = 0; halted = 1.
  - redirect, ihit and instr_ready are ignored.
- ihit while not in FETCH is ignored.
- Reset mid-operation: a pending fetch or held instruction is dropped; the next cycle after RST falls starts FETCH at PC_INIT.

Optional Feature:
- Macro: FETCH_ISSUE_UNIT_PERF_EN.
- Defined:
  - Adds output port issue_count (32 bits).
  - Increments on each acceptance, including the halting instruction.
  - Squashed/redirected instructions are not counted.
  - Saturates at 32'hFFFF_FFFF; resets to 0.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset, then ihit=1 with imemload=32'h2002_0005 on the first FETCH cycle, instr_ready=1 -> imemaddr=0; next cycle instr=32'h2002_0005, instr_valid=1, pc_plus4=4; next fetch at imemaddr=4.
- ihit delayed 3 cycles, instr_ready held 0 for 4 cycles in HOLD -> imemREN=1 for exactly 3 FETCH cycles; instr_valid stays 1 and instr stable until ready; no second fetch issued.
- redirect=1, redirect_pc=32'h0000_0103 in the same cycle as ihit -> returned word discarded; next imemaddr=32'h0000_0100; instr_valid=0.
- Accept instr 32'hFFFF_FFFF with halt=1 -> halted=1 and imemREN=0 from next cycle; later redirect and ihit produce no change; RST=1 restores pc=PC_INIT and halted=0.
- PC_INIT=32'hFFFF_FFFC, one fetch -> pc_plus4=0; next imemaddr=0 (wrap).
- With FETCH_ISSUE_UNIT_PERF_EN: 5 accepts, 1 redirected squash, then halt accept -> issue_count=6.
